// File: rtl/cpu_axi_bridge_pkg.sv
// Shared definitions for the CPU-to-AXI3 bridge: fixed transaction IDs,
// the AXI fields the SoC wrapper ties off, and the payload layouts held
// in the request slots.
package cpu_axi_bridge_pkg;

  // Read IDs used to steer R-channel responses back to the right port
  localparam logic [3:0] ID_INST = 4'd0;
  localparam logic [3:0] ID_DATA = 4'd1;

  // Constant AXI fields driven by the SoC wrapper, never by the bridge
  localparam logic [3:0] AXI_LEN        = 4'd0;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_LOCK       = 2'b00;
  localparam logic [3:0] AXI_CACHE      = 4'b0000;
  localparam logic [2:0] AXI_PROT       = 3'b000;
  localparam logic [2:0] AXI_SIZE       = 3'd2;
  localparam logic [3:0] AXI_WID        = 4'd1;
  localparam logic [3:0] AXI_AWID       = 4'd1;
  localparam logic       AXI_RREADY     = 1'b1;
  localparam logic       AXI_BREADY     = 1'b1;

  // Which CPU port owns the read currently being loaded into the AR slot
  typedef enum logic {
    SRC_INST = 1'b0,
    SRC_DATA = 1'b1
  } rd_src_e;

  // Read address slot contents
  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
  } ar_payload_t;

  // Write data slot contents
  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
  } w_payload_t;

  // Map the winning read source onto its AXI ID
  function automatic logic [3:0] src_to_id(rd_src_e src);
    return (src == SRC_DATA) ? ID_DATA : ID_INST;
  endfunction

endpackage

// File: rtl/cpu_axi_bridge_if.sv
// AXI3 master-side signal bundle for the bridge. Only the fields that
// actually vary are carried; constant fields live in the SoC wrapper.
interface cpu_axi_bridge_if;
  import cpu_axi_bridge_pkg::*;

  logic [3:0]  arid;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic        rvalid;

  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;

  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;

  logic        bvalid;

  modport master (
    output arid, araddr, arvalid,
    input  arready,
    input  rid, rdata, rvalid,
    output awaddr, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bvalid
  );

  modport slave (
    input  arid, araddr, arvalid,
    output arready,
    output rid, rdata, rvalid,
    input  awaddr, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bvalid
  );

endinterface

// File: rtl/cpu_axi_bridge_axi_req_slot.sv
// Single-entry AXI request holding register. The payload is captured when
// the slot is set and stays frozen until the channel handshake drains it,
// which keeps address/data stable while valid is high.
module axi_req_slot #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set_i,
  input  logic [WIDTH-1:0] payload_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] payload_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] payload_q, payload_d;

  // Set wins over clear; the owner only sets an empty slot, so a set never
  // overlaps a pending handshake on the same entry
  always_comb begin
    valid_d   = valid_q;
    payload_d = payload_q;
    if (set_i) begin
      valid_d   = 1'b1;
      payload_d = payload_i;
    end else if (valid_q && ready_i) begin
      valid_d   = 1'b0;
    end
  end

  // Register the slot state, discarding any in-flight request on reset
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= 1'b0;
      payload_q <= '0;
    end else begin
      valid_q   <= valid_d;
      payload_q <= payload_d;
    end
  end

  assign valid_o   = valid_q;
  assign payload_o = payload_q;

endmodule

// File: rtl/cpu_axi_bridge.sv
// Bridge from the core's split sram-like instruction/data request ports to
// a single AXI3 master. Reads from both ports share one AR slot with data
// given priority; stores use separate AW and W slots. Each port allows one
// outstanding operation, and responses are routed back by read ID.
module cpu_axi_bridge
  import cpu_axi_bridge_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,

  input  logic                   inst_req_i,
  input  logic [31:0]            inst_addr_i,
  output logic                   inst_addr_ok_o,
  output logic                   inst_data_ok_o,
  output logic [31:0]            inst_rdata_o,

  input  logic                   data_req_i,
  input  logic                   data_wr_i,
  input  logic [31:0]            data_addr_i,
  input  logic [3:0]             data_wstrb_i,
  input  logic [31:0]            data_wdata_i,
  output logic                   data_addr_ok_o,
  output logic                   data_data_ok_o,
  output logic [31:0]            data_rdata_o,

  cpu_axi_bridge_if.master       axi
);

  logic        inst_busy_q, inst_busy_d;
  logic        data_busy_q, data_busy_d;

  logic        ar_v, aw_v, w_v;
  logic        data_rd_cand, inst_cand;
  logic        data_rd_accept, inst_accept, wr_accept, data_accept;
  logic        inst_resp, data_resp;
  rd_src_e     rd_src;

  ar_payload_t ar_in, ar_out;
  w_payload_t  w_in, w_out;
  logic [31:0] aw_out;

  // Candidates for the shared AR slot
  assign data_rd_cand = data_req_i && !data_wr_i && !data_busy_q;
  assign inst_cand    = inst_req_i && !inst_busy_q;

  // Acceptance decisions; nothing is accepted during reset
  always_comb begin
    data_rd_accept = 1'b0;
    inst_accept    = 1'b0;
    wr_accept      = 1'b0;
    rd_src         = SRC_INST;
    if (!reset) begin
      if (!ar_v) begin
        if (data_rd_cand) begin
          data_rd_accept = 1'b1;
          rd_src         = SRC_DATA;
        end else if (inst_cand) begin
          inst_accept    = 1'b1;
        end
      end
      wr_accept = data_req_i && data_wr_i && !data_busy_q && !aw_v && !w_v;
    end
  end

  assign data_accept = data_rd_accept || wr_accept;

  // Response routing by ID; a write response always belongs to the data port
  assign inst_resp = !reset && axi.rvalid && (axi.rid == ID_INST);
  assign data_resp = !reset && ((axi.rvalid && (axi.rid == ID_DATA)) || axi.bvalid);

  assign ar_in.id   = src_to_id(rd_src);
  assign ar_in.addr = (rd_src == SRC_DATA) ? data_addr_i : inst_addr_i;
  assign w_in.data  = data_wdata_i;
  assign w_in.strb  = data_wstrb_i;

  axi_req_slot #(.WIDTH($bits(ar_payload_t))) u_ar_slot (
    .clk       (clk),
    .reset     (reset),
    .set_i     (data_rd_accept || inst_accept),
    .payload_i (ar_in),
    .ready_i   (axi.arready),
    .valid_o   (ar_v),
    .payload_o (ar_out)
  );

  axi_req_slot #(.WIDTH(32)) u_aw_slot (
    .clk       (clk),
    .reset     (reset),
    .set_i     (wr_accept),
    .payload_i (data_addr_i),
    .ready_i   (axi.awready),
    .valid_o   (aw_v),
    .payload_o (aw_out)
  );

  axi_req_slot #(.WIDTH($bits(w_payload_t))) u_w_slot (
    .clk       (clk),
    .reset     (reset),
    .set_i     (wr_accept),
    .payload_i (w_in),
    .ready_i   (axi.wready),
    .valid_o   (w_v),
    .payload_o (w_out)
  );

  // Busy flags span from address acceptance to the matching response
  always_comb begin
    inst_busy_d = inst_busy_q;
    data_busy_d = data_busy_q;
    if (inst_accept) begin
      inst_busy_d = 1'b1;
    end else if (inst_resp) begin
      inst_busy_d = 1'b0;
    end
    if (data_accept) begin
      data_busy_d = 1'b1;
    end else if (data_resp) begin
      data_busy_d = 1'b0;
    end
  end

  // Register the busy flags; reset abandons anything outstanding
  always_ff @(posedge clk) begin
    if (reset) begin
      inst_busy_q <= 1'b0;
      data_busy_q <= 1'b0;
    end else begin
      inst_busy_q <= inst_busy_d;
      data_busy_q <= data_busy_d;
    end
  end

  assign axi.arvalid = ar_v;
  assign axi.arid    = ar_out.id;
  assign axi.araddr  = ar_out.addr;
  assign axi.awvalid = aw_v;
  assign axi.awaddr  = aw_out;
  assign axi.wvalid  = w_v;
  assign axi.wdata   = w_out.data;
  assign axi.wstrb   = w_out.strb;

  assign inst_addr_ok_o = inst_accept;
  assign data_addr_ok_o = data_accept;
  assign inst_data_ok_o = inst_resp;
  assign data_data_ok_o = data_resp;
  assign inst_rdata_o   = axi.rdata;
  assign data_rdata_o   = axi.rdata;

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// Directed testbench for cpu_axi_bridge. The bench plays both the CPU and
// the AXI slave, stepping cycle by cycle with hand-computed expectations.
module tb_cpu_axi_bridge;
  import cpu_axi_bridge_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_addr_ok, inst_data_ok;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [3:0]  data_wstrb;

  int checkCount = 0;
  int errorCount = 0;

  cpu_axi_bridge_if axi();

  cpu_axi_bridge dut (
    .clk            (clk),
    .reset          (reset),
    .inst_req_i     (inst_req),
    .inst_addr_i    (inst_addr),
    .inst_addr_ok_o (inst_addr_ok),
    .inst_data_ok_o (inst_data_ok),
    .inst_rdata_o   (inst_rdata),
    .data_req_i     (data_req),
    .data_wr_i      (data_wr),
    .data_addr_i    (data_addr),
    .data_wstrb_i   (data_wstrb),
    .data_wdata_i   (data_wdata),
    .data_addr_ok_o (data_addr_ok),
    .data_data_ok_o (data_data_ok),
    .data_rdata_o   (data_rdata),
    .axi            (axi)
  );

  // Free-running clock, period 10
  always #5 clk = ~clk;

  // Advance to just after the next rising edge so inputs change mid-cycle
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Drive the CPU-side request ports
  task automatic applyStimulus(input logic iReq, input logic [31:0] iAddr,
                               input logic dReq, input logic dWr,
                               input logic [31:0] dAddr, input logic [3:0] dStrb,
                               input logic [31:0] dWdata);
    inst_req   = iReq;
    inst_addr  = iAddr;
    data_req   = dReq;
    data_wr    = dWr;
    data_addr  = dAddr;
    data_wstrb = dStrb;
    data_wdata = dWdata;
    #1;
  endtask

  // Compare one observed value against its expectation
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected)
    else begin
      errorCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    reset       = 1'b1;
    axi.arready = 1'b0;
    axi.rvalid  = 1'b0;
    axi.rid     = 4'd0;
    axi.rdata   = 32'h0;
    axi.awready = 1'b0;
    axi.wready  = 1'b0;
    axi.bvalid  = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);

    // Reset state, with a request pending to prove addr_ok is suppressed
    tick();
    applyStimulus(1'b1, 32'h1c000000, 1'b1, 1'b0, 32'h1000, 4'h0, 32'h0);
    checkOutput("rst_arvalid", 32'(axi.arvalid), 32'd0);
    checkOutput("rst_awvalid", 32'(axi.awvalid), 32'd0);
    checkOutput("rst_wvalid", 32'(axi.wvalid), 32'd0);
    checkOutput("rst_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
    checkOutput("rst_data_addr_ok", 32'(data_addr_ok), 32'd0);
    checkOutput("rst_data_data_ok", 32'(data_data_ok), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    tick();
    reset = 1'b0;
    tick();

    // Inst read with arready held off for two cycles
    applyStimulus(1'b1, 32'h1c000000, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    checkOutput("t1_inst_addr_ok", 32'(inst_addr_ok), 32'd1);
    checkOutput("t1_arvalid_pre", 32'(axi.arvalid), 32'd0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    checkOutput("t1_arvalid_c1", 32'(axi.arvalid), 32'd1);
    checkOutput("t1_araddr_c1", axi.araddr, 32'h1c000000);
    checkOutput("t1_arid", 32'(axi.arid), 32'd0);
    checkOutput("t1_inst_addr_ok_once", 32'(inst_addr_ok), 32'd0);
    tick();
    checkOutput("t1_araddr_c2", axi.araddr, 32'h1c000000);
    checkOutput("t1_arvalid_c2", 32'(axi.arvalid), 32'd1);
    tick();
    axi.arready = 1'b1;
    #1;
    checkOutput("t1_araddr_c3", axi.araddr, 32'h1c000000);
    tick();
    axi.arready = 1'b0;
    axi.rvalid  = 1'b1;
    axi.rid     = 4'd0;
    axi.rdata   = 32'h02800c0c;
    applyStimulus(1'b1, 32'h1c000004, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    checkOutput("t1_arvalid_drop", 32'(axi.arvalid), 32'd0);
    checkOutput("t1_inst_data_ok", 32'(inst_data_ok), 32'd1);
    checkOutput("t1_inst_rdata", inst_rdata, 32'h02800c0c);
    checkOutput("t1_data_data_ok", 32'(data_data_ok), 32'd0);
    checkOutput("t1_inst_busy_block", 32'(inst_addr_ok), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    tick();
    axi.rvalid = 1'b0;
    #1;
    checkOutput("t1_inst_data_ok_pulse", 32'(inst_data_ok), 32'd0);
    tick();

    // Simultaneous inst fetch and data load: data wins the AR slot
    applyStimulus(1'b1, 32'h1c000004, 1'b1, 1'b0, 32'h1000, 4'h0, 32'h0);
    checkOutput("t2_data_addr_ok", 32'(data_addr_ok), 32'd1);
    checkOutput("t2_inst_addr_ok_lose", 32'(inst_addr_ok), 32'd0);
    tick();
    axi.arready = 1'b1;
    applyStimulus(1'b1, 32'h1c000004, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    checkOutput("t2_arid_data", 32'(axi.arid), 32'd1);
    checkOutput("t2_araddr_data", axi.araddr, 32'h1000);
    checkOutput("t2_inst_addr_ok_arready", 32'(inst_addr_ok), 32'd0);
    tick();
    axi.arready = 1'b0;
    #1;
    checkOutput("t2_inst_addr_ok_after", 32'(inst_addr_ok), 32'd1);
    tick();
    axi.arready = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    checkOutput("t2_arid_inst", 32'(axi.arid), 32'd0);
    checkOutput("t2_araddr_inst", axi.araddr, 32'h1c000004);
    tick();
    axi.arready = 1'b0;
    axi.rvalid  = 1'b1;
    axi.rid     = 4'd1;
    axi.rdata   = 32'haaaa5555;
    #1;
    checkOutput("t2_data_data_ok", 32'(data_data_ok), 32'd1);
    checkOutput("t2_data_rdata", data_rdata, 32'haaaa5555);
    checkOutput("t2_inst_data_ok_idle", 32'(inst_data_ok), 32'd0);
    tick();
    axi.rid   = 4'd0;
    axi.rdata = 32'h11112222;
    #1;
    checkOutput("t2_inst_data_ok", 32'(inst_data_ok), 32'd1);
    checkOutput("t2_inst_rdata", inst_rdata, 32'h11112222);
    checkOutput("t2_data_data_ok_idle", 32'(data_data_ok), 32'd0);
    tick();
    axi.rvalid = 1'b0;

    // Store with awready at cycle 1 and wready at cycle 3
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h2000, 4'h3, 32'h12345678);
    checkOutput("t3_data_addr_ok", 32'(data_addr_ok), 32'd1);
    checkOutput("t3_awvalid_pre", 32'(axi.awvalid), 32'd0);
    tick();
    axi.awready = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    checkOutput("t3_awvalid_c1", 32'(axi.awvalid), 32'd1);
    checkOutput("t3_awaddr", axi.awaddr, 32'h2000);
    checkOutput("t3_wvalid_c1", 32'(axi.wvalid), 32'd1);
    checkOutput("t3_wdata", axi.wdata, 32'h12345678);
    checkOutput("t3_wstrb", 32'(axi.wstrb), 32'h3);
    tick();
    axi.awready = 1'b0;
    #1;
    checkOutput("t3_awvalid_c2", 32'(axi.awvalid), 32'd0);
    checkOutput("t3_wvalid_c2", 32'(axi.wvalid), 32'd1);
    tick();
    axi.wready = 1'b1;
    #1;
    checkOutput("t3_wvalid_c3", 32'(axi.wvalid), 32'd1);
    checkOutput("t3_no_early_ok", 32'(data_data_ok), 32'd0);
    tick();
    axi.wready = 1'b0;

    // Load to the same address stalls until the store's bvalid
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h2000, 4'h0, 32'h0);
    checkOutput("t3_wvalid_c4", 32'(axi.wvalid), 32'd0);
    checkOutput("t4_load_stall", 32'(data_addr_ok), 32'd0);
    checkOutput("t4_arvalid_stall", 32'(axi.arvalid), 32'd0);
    tick();
    axi.bvalid = 1'b1;
    #1;
    checkOutput("t3_bvalid_ok", 32'(data_data_ok), 32'd1);
    checkOutput("t4_load_stall_bvalid", 32'(data_addr_ok), 32'd0);
    tick();
    axi.bvalid = 1'b0;
    #1;
    checkOutput("t4_load_accept", 32'(data_addr_ok), 32'd1);
    checkOutput("t3_ok_pulse", 32'(data_data_ok), 32'd0);
    tick();
    axi.arready = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    checkOutput("t4_arid", 32'(axi.arid), 32'd1);
    checkOutput("t4_araddr", axi.araddr, 32'h2000);
    tick();
    axi.arready = 1'b0;
    axi.rvalid  = 1'b1;
    axi.rid     = 4'd1;
    axi.rdata   = 32'h0000abcd;
    #1;
    checkOutput("t4_data_data_ok", 32'(data_data_ok), 32'd1);
    checkOutput("t4_data_rdata", data_rdata, 32'h0000abcd);
    tick();
    axi.rvalid = 1'b0;

    // Data read returns before an older inst read
    applyStimulus(1'b1, 32'h1c000010, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    checkOutput("t5_inst_addr_ok", 32'(inst_addr_ok), 32'd1);
    tick();
    axi.arready = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h3000, 4'h0, 32'h0);
    checkOutput("t5_no_accept_arready", 32'(data_addr_ok), 32'd0);
    tick();
    axi.arready = 1'b0;
    #1;
    checkOutput("t5_data_addr_ok", 32'(data_addr_ok), 32'd1);
    tick();
    axi.arready = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    checkOutput("t5_arid", 32'(axi.arid), 32'd1);
    checkOutput("t5_araddr", axi.araddr, 32'h3000);
    tick();
    axi.arready = 1'b0;
    axi.rvalid  = 1'b1;
    axi.rid     = 4'd1;
    axi.rdata   = 32'hcafef00d;
    #1;
    checkOutput("t5_data_data_ok", 32'(data_data_ok), 32'd1);
    checkOutput("t5_data_rdata", data_rdata, 32'hcafef00d);
    checkOutput("t5_inst_quiet", 32'(inst_data_ok), 32'd0);
    tick();
    axi.rid   = 4'd0;
    axi.rdata = 32'h01234567;
    #1;
    checkOutput("t5_inst_data_ok", 32'(inst_data_ok), 32'd1);
    checkOutput("t5_inst_rdata", inst_rdata, 32'h01234567);
    checkOutput("t5_data_quiet", 32'(data_data_ok), 32'd0);
    tick();
    axi.rvalid = 1'b0;

    // Reset while arvalid waits for arready
    applyStimulus(1'b1, 32'h1c000020, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    checkOutput("t6_inst_addr_ok", 32'(inst_addr_ok), 32'd1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    checkOutput("t6_arvalid_pending", 32'(axi.arvalid), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    applyStimulus(1'b1, 32'h1c000024, 1'b1, 1'b1, 32'h4000, 4'hf, 32'h55aa55aa);
    checkOutput("t6_arvalid_cleared", 32'(axi.arvalid), 32'd0);
    checkOutput("t6_no_inst_data_ok", 32'(inst_data_ok), 32'd0);
    checkOutput("t6_no_data_data_ok", 32'(data_data_ok), 32'd0);
    checkOutput("t6_inst_busy_clear", 32'(inst_addr_ok), 32'd1);
    checkOutput("t6_data_busy_clear", 32'(data_addr_ok), 32'd1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    checkOutput("t6_araddr_new", axi.araddr, 32'h1c000024);
    checkOutput("t6_awaddr_new", axi.awaddr, 32'h4000);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
